// File: rtl/led_pio_write_arbiter.sv
// ---------------------------------------------------------------------------
// led_pio_write_arbiter
//
// Shares the single green-LED PIO slave between two independent requesters
// (for example the Nios II status path and the spectrum peak-meter).
// Each requester raises req with its LED value on data and holds both until
// it sees a one-cycle ack. A round-robin arbiter grants one requester at a
// time. Each grant produces exactly one Avalon-MM write to PIO word
// address 0, followed by a programmable idle gap. A shadow register keeps
// the last value written, so software never has to read the PIO back.
//
// Parameters
//   DATA_W      LED data width (upper pio_writedata bits are zero-padded)
//   GAP_CYCLES  idle cycles after each PIO write before the next grant
//               (legal range 0..255)
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   req0 / data0    requester 0 write request and LED value
//   ack0            one-cycle pulse: requester 0 value has been written
//   req1 / data1    requester 1 write request and LED value
//   ack1            one-cycle pulse: requester 1 value has been written
//   pio_chipselect  PIO slave chipselect
//   pio_write_n     PIO slave write strobe, active low
//   pio_address     PIO slave word address, tied to 0
//   pio_writedata   zero-padded granted LED value
//   shadow          last value written to the PIO
//   busy            high whenever the arbiter is not idle
//
// All outputs except the constant pio_address are registered and move
// together with the state register. As a result, the WRITE cycle, the
// chipselect/write strobe and the matching ack all occupy the same clock
// cycle.
// ---------------------------------------------------------------------------
module led_pio_write_arbiter #(
    parameter int DATA_W     = 9,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [1:0]        pio_address,
    output logic [31:0]       pio_writedata,
    output logic [DATA_W-1:0] shadow,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Value loaded into the gap counter when GAP is entered. The counter
    // counts GAP_LOAD..0, so the gap lasts exactly GAP_CYCLES cycles. When
    // GAP_CYCLES is 0 the GAP state is never entered, and the load value
    // is then irrelevant.
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t              state, state_n;
    logic                last_grant, last_grant_n;
    logic [7:0]          gap_cnt, gap_cnt_n;
    logic                ack0_n, ack1_n;
    logic                cs_n, write_n_n;
    logic [31:0]         writedata_n;
    logic [DATA_W-1:0]   shadow_n;
    logic                busy_n;

    // The block only writes, and it writes only to word 0.
    assign pio_address = 2'b00;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement. This
        // means no path through the block leaves a signal unassigned, so no
        // latch is inferred.
        state_n      = state;
        last_grant_n = last_grant;
        gap_cnt_n    = gap_cnt;
        ack0_n       = 1'b0;
        ack1_n       = 1'b0;
        cs_n         = 1'b0;
        write_n_n    = 1'b1;
        writedata_n  = pio_writedata;
        shadow_n     = shadow;

        case (state)
            IDLE: begin
                // Requester 0 wins when it is alone or when requester 1
                // had the previous grant. Otherwise requester 1 wins if it
                // is asking.
                if (req0 && (!req1 || last_grant)) begin
                    state_n      = WRITE;
                    last_grant_n = 1'b0;
                    writedata_n  = 32'(data0);
                    shadow_n     = data0;
                    cs_n         = 1'b1;
                    write_n_n    = 1'b0;
                    ack0_n       = 1'b1;
                end else if (req1) begin
                    state_n      = WRITE;
                    last_grant_n = 1'b1;
                    writedata_n  = 32'(data1);
                    shadow_n     = data1;
                    cs_n         = 1'b1;
                    write_n_n    = 1'b0;
                    ack1_n       = 1'b1;
                end
            end

            WRITE: begin
                // The strobe and ack drop back to their defaults here, so
                // the write lasts exactly one cycle.
                if (GAP_CYCLES > 0) begin
                    state_n   = GAP;
                    gap_cnt_n = GAP_LOAD;
                end else begin
                    state_n   = IDLE;
                end
            end

            GAP: begin
                // Requests are ignored here. A request that is withdrawn
                // before IDLE is reached is dropped without a write.
                if (gap_cnt == 8'd0) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt - 8'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;   // requester 0 wins the first tie
            gap_cnt        <= 8'd0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= 32'd0;
            shadow         <= '0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            last_grant     <= last_grant_n;
            gap_cnt        <= gap_cnt_n;
            ack0           <= ack0_n;
            ack1           <= ack1_n;
            pio_chipselect <= cs_n;
            pio_write_n    <= write_n_n;
            pio_writedata  <= writedata_n;
            shadow         <= shadow_n;
            busy           <= busy_n;
        end
    end

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for led_pio_write_arbiter.
// Instance dut runs with GAP_CYCLES=4; instance dut_z runs with
// GAP_CYCLES=0. Both instances share clk and reset.
// ---------------------------------------------------------------------------
module tb_led_pio_write_arbiter;

    localparam int DATA_W = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // GAP_CYCLES = 4 instance
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [DATA_W-1:0] data0 = '0, data1 = '0;
    logic              ack0, ack1, cs, write_n, busy;
    logic [1:0]        addr;
    logic [31:0]       wdata;
    logic [DATA_W-1:0] shadow;

    // GAP_CYCLES = 0 instance
    logic              req0_z = 1'b0, req1_z = 1'b0;
    logic [DATA_W-1:0] data0_z = '0, data1_z = '0;
    logic              ack0_z, ack1_z, cs_z, write_n_z, busy_z;
    logic [1:0]        addr_z;
    logic [31:0]       wdata_z;
    logic [DATA_W-1:0] shadow_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pio_write_arbiter #(.DATA_W(DATA_W), .GAP_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .pio_chipselect(cs), .pio_write_n(write_n), .pio_address(addr),
        .pio_writedata(wdata), .shadow(shadow), .busy(busy)
    );

    led_pio_write_arbiter #(.DATA_W(DATA_W), .GAP_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req0(req0_z), .data0(data0_z), .ack0(ack0_z),
        .req1(req1_z), .data1(data1_z), .ack1(ack1_z),
        .pio_chipselect(cs_z), .pio_write_n(write_n_z), .pio_address(addr_z),
        .pio_writedata(wdata_z), .shadow(shadow_z), .busy(busy_z)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One record per clock cycle: inputs applied before the edge, and the
    // outputs expected just after it.
    typedef struct {
        logic              r0;
        logic              r1;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic              cs;
        logic              a0;
        logic              a1;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] sh;
        logic              bz;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_wr;
        int last_c;
        int exp_g;
        bit stray;
        bit seen;

        //              r0 r1 d0      d1      cs a0 a1 wd      sh      bz
        vecs[0]  = '{1'b1, 1'b0, 9'h155, 9'h000, 1'b1, 1'b1, 1'b0, 9'h155, 9'h155, 1'b1}; // grant 0
        vecs[1]  = '{1'b0, 1'b0, 9'h155, 9'h000, 1'b0, 1'b0, 1'b0, 9'h155, 9'h155, 1'b1}; // gap 3
        vecs[2]  = '{1'b0, 1'b0, 9'h155, 9'h000, 1'b0, 1'b0, 1'b0, 9'h155, 9'h155, 1'b1}; // gap 2
        vecs[3]  = '{1'b0, 1'b0, 9'h155, 9'h000, 1'b0, 1'b0, 1'b0, 9'h155, 9'h155, 1'b1}; // gap 1
        vecs[4]  = '{1'b0, 1'b0, 9'h155, 9'h000, 1'b0, 1'b0, 1'b0, 9'h155, 9'h155, 1'b1}; // gap 0
        vecs[5]  = '{1'b0, 1'b0, 9'h155, 9'h000, 1'b0, 1'b0, 1'b0, 9'h155, 9'h155, 1'b0}; // idle
        vecs[6]  = '{1'b0, 1'b1, 9'h000, 9'h100, 1'b1, 1'b0, 1'b1, 9'h100, 9'h100, 1'b1}; // grant 1
        vecs[7]  = '{1'b1, 1'b0, 9'h0F0, 9'h100, 1'b0, 1'b0, 1'b0, 9'h100, 9'h100, 1'b1}; // req0 pulse in gap
        vecs[8]  = '{1'b0, 1'b0, 9'h0F0, 9'h100, 1'b0, 1'b0, 1'b0, 9'h100, 9'h100, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 9'h0F0, 9'h100, 1'b0, 1'b0, 1'b0, 9'h100, 9'h100, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 9'h0F0, 9'h100, 1'b0, 1'b0, 1'b0, 9'h100, 9'h100, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 9'h0F0, 9'h100, 1'b0, 1'b0, 1'b0, 9'h100, 9'h100, 1'b0}; // idle, no write
        vecs[12] = '{1'b0, 1'b0, 9'h0F0, 9'h100, 1'b0, 1'b0, 1'b0, 9'h100, 9'h100, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 9'h0AA, 9'h000, 1'b1, 1'b1, 1'b0, 9'h0AA, 9'h0AA, 1'b1}; // grant 0
        vecs[14] = '{1'b0, 1'b0, 9'h055, 9'h000, 1'b0, 1'b0, 1'b0, 9'h0AA, 9'h0AA, 1'b1}; // data change after grant

        // ---------------- reset state ----------------
        #12;
        check("rst cs", 32'(cs), 32'd0);
        check("rst write_n", 32'(write_n), 32'd1);
        check("rst addr", 32'(addr), 32'd0);
        check("rst wdata", wdata, 32'd0);
        check("rst shadow", 32'(shadow), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst acks", {30'd0, ack0, ack1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table-driven vectors (GAP_CYCLES=4) ----------------
        for (int i = 0; i < NVEC; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            data0 = vecs[i].d0; data1 = vecs[i].d1;
            @(posedge clk); #1;
            check($sformatf("vec%0d cs", i), 32'(cs), 32'(vecs[i].cs));
            check($sformatf("vec%0d write_n", i), 32'(write_n), 32'(!vecs[i].cs));
            check($sformatf("vec%0d ack0", i), 32'(ack0), 32'(vecs[i].a0));
            check($sformatf("vec%0d ack1", i), 32'(ack1), 32'(vecs[i].a1));
            check($sformatf("vec%0d wdata", i), wdata, 32'(vecs[i].wd));
            check($sformatf("vec%0d shadow", i), 32'(shadow), 32'(vecs[i].sh));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bz));
            check($sformatf("vec%0d addr", i), 32'(addr), 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // ---------------- both held: alternate 0,1,0,1 with spacing 6 ----------------
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b1; data0 = 9'h001;
        req1 = 1'b1; data1 = 9'h100;
        @(negedge clk);
        reset = 1'b0;
        n_wr = 0; last_c = 0; stray = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (cs) begin
                exp_g = n_wr % 2;
                check($sformatf("rr%0d acks", n_wr), {30'd0, ack0, ack1},
                      (exp_g == 0) ? 32'd2 : 32'd1);
                check($sformatf("rr%0d wdata", n_wr), wdata,
                      (exp_g == 0) ? 32'h001 : 32'h100);
                if (n_wr > 0)
                    check($sformatf("rr%0d spacing", n_wr), 32'(c - last_c), 32'd6);
                last_c = c;
                n_wr++;
            end else if (ack0 || ack1) begin
                stray = 1'b1;
            end
        end
        check("rr write count", 32'(n_wr), 32'd5);
        check("rr stray ack", 32'(stray), 32'd0);
        req0 = 1'b0; req1 = 1'b0;

        // ---------------- GAP_CYCLES=0: write every 2nd cycle ----------------
        @(negedge clk);
        reset = 1'b1;
        req1_z = 1'b1; data1_z = 9'h1FF;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check($sformatf("g0 c%0d cs", c), 32'(cs_z), (c % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("g0 c%0d ack1", c), 32'(ack1_z), 32'(cs_z));
            if (ack0_z) check($sformatf("g0 c%0d ack0", c), 32'(ack0_z), 32'd0);
        end
        check("g0 shadow", 32'(shadow_z), 32'h1FF);
        check("g0 wdata", wdata_z, 32'h1FF);
        req1_z = 1'b0;

        // ---------------- reset during WRITE ----------------
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b1; data0 = 9'h0AA;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (cs) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstw write seen", 32'(seen), 32'd1);
        reset = 1'b1;
        #1;
        check("rstw cs", 32'(cs), 32'd0);
        check("rstw write_n", 32'(write_n), 32'd1);
        check("rstw ack0", 32'(ack0), 32'd0);
        check("rstw shadow", 32'(shadow), 32'd0);
        check("rstw busy", 32'(busy), 32'd0);
        req0 = 1'b1; data0 = 9'h003;
        req1 = 1'b1; data1 = 9'h004;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstw tie ack0", 32'(ack0), 32'd1);
        check("rstw tie ack1", 32'(ack1), 32'd0);
        check("rstw tie wdata", wdata, 32'h003);
        req0 = 1'b0; req1 = 1'b0;

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
